// File: rtl/dbg_pkg.sv
// Shared constants for the pipeline debug controller: command bytes, FSM
// state encoding and the layout of the post-run dump (PC, GPRs, data memory,
// optional cycle counter).
// Optional feature macro: DBG_CYCLE_COUNT_EN adds one trailing dump word.
package dbg_pkg;

  localparam logic [7:0] CMD_RUN_DEF  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_STEP_DEF = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RST_DEF  = 8'h52;  // 'R'

  localparam int GPR_COUNT     = 32;
  localparam int DUMP_PC       = 0;
  localparam int DUMP_REG_BASE = DUMP_PC + 1;
  localparam int DUMP_MEM_BASE = DUMP_REG_BASE + GPR_COUNT;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_STEP    = 3'd2;
  localparam logic [2:0] ST_LOAD    = 3'd3;
  localparam logic [2:0] ST_LATCH   = 3'd4;
  localparam logic [2:0] ST_SEND    = 3'd5;
  localparam logic [2:0] ST_WAIT_TX = 3'd6;

`ifdef DBG_CYCLE_COUNT_EN
  localparam int EXTRA_WORDS = 1;
`else
  localparam int EXTRA_WORDS = 0;
`endif

  // Number of 32-bit words in one dump.
  function automatic int dump_words(input int mem_words);
    return DUMP_MEM_BASE + mem_words + EXTRA_WORDS;
  endfunction

endpackage

// File: rtl/dbg_word_tx.sv
// Serialises one 32-bit word into four UART bytes, LSB first.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           1-cycle request; word must stay stable until done
//   word            word to send
//   tx_busy         transmitter busy
//   tx_data         byte to send
//   tx_start        1-cycle strobe per byte
//   done            1-cycle pulse after the fourth byte has left the UART
module dbg_word_tx
  import dbg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        done
);

  logic [2:0] state;
  logic [1:0] byte_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      byte_idx <= 2'd0;
      tx_data  <= 8'd0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of the others, independent of statement order.
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            byte_idx <= 2'd0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_data  <= word[{byte_idx, 3'b000} +: 8];
            tx_start <= 1'b1;
            state    <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          // While tx_start is still high the UART has not yet raised busy,
          // so that first cycle is skipped.
          if (!tx_start && !tx_busy) begin
            if (byte_idx == 2'd3) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              state    <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Host-driven debug controller for the 5-stage MIPS pipeline. Decodes UART
// command bytes, gates the pipeline clock-enable (run / single-step) and,
// after a run ends, dumps PC, the 32 GPRs and MEM_WORDS data-memory words
// over the UART, 4 bytes per word, LSB first.
// Optional feature macro: DBG_CYCLE_COUNT_EN -- 32-bit count of enabled
// pipeline cycles, appended as the final dump word.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   rx_data, rx_valid          received command byte + strobe
//   tx_data, tx_start, tx_busy UART transmit byte interface
//   pipe_en, pipe_reset        pipeline clock-enable, 1-cycle pipeline reset
//   wb_halt                    halt instruction reached WB
//   pc_value                   current IF PC
//   dbg_reg_addr/dbg_reg_data  register-file debug read port
//   dbg_mem_addr/dbg_mem_data  data-memory debug read port (1-cycle latency)
//   halted                     program has halted
module debug_unit_ctrl
  import dbg_pkg::*;
#(
  parameter int         MEM_WORDS = 32,
  parameter logic [7:0] CMD_RUN   = CMD_RUN_DEF,
  parameter logic [7:0] CMD_STEP  = CMD_STEP_DEF,
  parameter logic [7:0] CMD_RST   = CMD_RST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        pipe_en,
  output logic        pipe_reset,
  input  logic        wb_halt,
  input  logic [31:0] pc_value,
  output logic [4:0]  dbg_reg_addr,
  input  logic [31:0] dbg_reg_data,
  output logic [31:0] dbg_mem_addr,
  input  logic [31:0] dbg_mem_data,
  output logic        halted
);

  localparam logic [8:0] W_REG_BASE = 9'(DUMP_REG_BASE);
  localparam logic [8:0] W_MEM_BASE = 9'(DUMP_MEM_BASE);
  localparam logic [8:0] W_MEM_END  = 9'(DUMP_MEM_BASE + MEM_WORDS);
  localparam logic [8:0] LAST_WORD  = 9'(dump_words(MEM_WORDS) - 1);

  logic [2:0]  state;
  logic [8:0]  word_idx;
  logic [31:0] word_q;
  logic [31:0] word_sel;
  logic        word_start;
  logic        word_done;
  logic        rst_cmd;

  assign rst_cmd = (state == ST_IDLE) && rx_valid && (rx_data == CMD_RST);

  // The enable drops combinationally in the cycle wb_halt is seen so the
  // halt instruction never advances past WB.
  assign pipe_en = ((state == ST_RUN) && !wb_halt) || (state == ST_STEP);

  // Debug addresses follow the word index; outside their own range they
  // read as zero.
  assign dbg_reg_addr = (word_idx >= W_REG_BASE && word_idx < W_MEM_BASE)
                        ? 5'(word_idx - W_REG_BASE) : 5'd0;
  assign dbg_mem_addr = (word_idx >= W_MEM_BASE && word_idx < W_MEM_END)
                        ? {21'd0, word_idx - W_MEM_BASE, 2'b00} : 32'd0;

`ifdef DBG_CYCLE_COUNT_EN
  logic [31:0] cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cycle_cnt <= 32'd0;
    else if (rst_cmd) cycle_cnt <= 32'd0;
    else if (pipe_en) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    word_sel = pc_value;
`ifdef DBG_CYCLE_COUNT_EN
    if (word_idx >= W_MEM_END)       word_sel = cycle_cnt;
    else if (word_idx >= W_MEM_BASE) word_sel = dbg_mem_data;
`else
    if (word_idx >= W_MEM_BASE)      word_sel = dbg_mem_data;
`endif
    else if (word_idx >= W_REG_BASE) word_sel = dbg_reg_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      word_idx   <= 9'd0;
      word_q     <= 32'd0;
      halted     <= 1'b0;
      pipe_reset <= 1'b0;
      word_start <= 1'b0;
    end else begin
      pipe_reset <= 1'b0;
      word_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rst_cmd) begin
            pipe_reset <= 1'b1;
            halted     <= 1'b0;
          end else if (rx_valid && !halted) begin
            if (rx_data == CMD_RUN)       state <= ST_RUN;
            else if (rx_data == CMD_STEP) state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (wb_halt) begin
            halted   <= 1'b1;
            word_idx <= 9'd0;
            state    <= ST_LOAD;
          end
        end
        ST_STEP: begin
          if (wb_halt) halted <= 1'b1;
          word_idx <= 9'd0;
          state    <= ST_LOAD;
        end
        // Address is presented here; synchronous memory answers in LATCH.
        ST_LOAD: state <= ST_LATCH;
        ST_LATCH: begin
          word_q     <= word_sel;
          word_start <= 1'b1;
          state      <= ST_SEND;
        end
        ST_SEND: begin
          if (word_done) begin
            if (word_idx == LAST_WORD) begin
              state <= ST_IDLE;
            end else begin
              word_idx <= word_idx + 9'd1;
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dbg_word_tx u_word_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (word_start),
    .word     (word_q),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (word_done)
  );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Testbench for debug_unit_ctrl: models the UART transmitter, register file,
// synchronous data memory and PC source, and compares the byte stream and
// pipeline controls with the values the debug protocol requires.
module tb_debug_unit_ctrl;

  localparam int MEM_WORDS = 32;
`ifdef DBG_CYCLE_COUNT_EN
  localparam int DUMP_BYTES = 4 * (34 + MEM_WORDS);
`else
  localparam int DUMP_BYTES = 4 * (33 + MEM_WORDS);
`endif
  localparam logic [7:0] C_RUN  = 8'h43;
  localparam logic [7:0] C_STEP = 8'h53;
  localparam logic [7:0] C_RST  = 8'h52;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        pipe_en;
  logic        pipe_reset;
  logic        wb_halt = 1'b0;
  logic [31:0] pc_value;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_data;
  logic [31:0] dbg_mem_addr;
  logic [31:0] dbg_mem_data = 32'd0;
  logic        halted;

  debug_unit_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .pipe_en      (pipe_en),
    .pipe_reset   (pipe_reset),
    .wb_halt      (wb_halt),
    .pc_value     (pc_value),
    .dbg_reg_addr (dbg_reg_addr),
    .dbg_reg_data (dbg_reg_data),
    .dbg_mem_addr (dbg_mem_addr),
    .dbg_mem_data (dbg_mem_data),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Environment model state.
  logic [31:0] pc_base = 32'd0;
  logic [31:0] regs [32];
  logic [31:0] mem_model [MEM_WORDS];
  logic [7:0]  cap [$];
  logic [7:0]  exp_q [$];
  int          busy_fixed = 0;
  int          tx_busy_cnt = 0;
  int          en_total = 0;
  int          en_since_rst = 0;
  int          rst_pulses = 0;
  int          addr8_hits = 0;
  int          proto_err = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  assign pc_value     = pc_base;
  assign dbg_reg_data = regs[dbg_reg_addr];

  always @(posedge clk) dbg_mem_data <= mem_model[dbg_mem_addr[6:2]];

  // UART transmitter and pipeline observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (pipe_en) begin
      en_total     <= en_total + 1;
      en_since_rst <= en_since_rst + 1;
    end
    if (pipe_reset) begin
      rst_pulses   <= rst_pulses + 1;
      en_since_rst <= 0;
    end
    if (dbg_mem_addr == 32'd8) addr8_hits <= addr8_hits + 1;
    if (tx_start) begin
      if (tx_busy) proto_err <= proto_err + 1;
      cap.push_back(tx_data);
      tx_busy_cnt <= (busy_fixed != 0) ? busy_fixed : int'($urandom_range(4, 1));
      tx_busy     <= 1'b1;
    end else if (tx_busy_cnt > 1) begin
      tx_busy_cnt <= tx_busy_cnt - 1;
    end else begin
      tx_busy_cnt <= 0;
      tx_busy     <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic randomize_model();
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < MEM_WORDS; i++) mem_model[i] = $urandom;
    pc_base = $urandom & 32'hFFFF_FFFC;
  endtask

  // Expected dump: every word of the debug view, 4 bytes each, LSB first.
  task automatic build_exp();
    logic [31:0] words [$];
    words.push_back(pc_base);
    for (int i = 0; i < 32; i++) words.push_back(regs[i]);
    for (int i = 0; i < MEM_WORDS; i++) words.push_back(mem_model[i]);
`ifdef DBG_CYCLE_COUNT_EN
    words.push_back(en_since_rst);
`endif
    exp_q.delete();
    foreach (words[i])
      for (int b = 0; b < 4; b++) exp_q.push_back(words[i][8*b +: 8]);
  endtask

  // Waits (bounded) for a full dump after cap index 'base' and compares it.
  task automatic check_dump(input string tag, input int base);
    int n = 0;
    int budget = DUMP_BYTES * (busy_fixed + 8) + 200;
    while (cap.size() < base + DUMP_BYTES && n < budget) begin
      tick();
      n++;
    end
    repeat (busy_fixed + 20) tick();
    build_exp();
    check({tag, "_len"}, cap.size() - base, DUMP_BYTES);
    for (int i = 0; i < DUMP_BYTES; i++)
      if (base + i < cap.size())
        check($sformatf("%s_byte%0d", tag, i), cap[base + i], exp_q[i]);
  endtask

  task automatic do_run(input int k);
    int en0 = en_total;
    send_byte(C_RUN);
    repeat (k) tick();
    wb_halt = 1'b1;
    #1;
    check("run_en_drop", pipe_en, 0);
    tick();
    check("run_halted", halted, 1);
    check("run_en_cycles", en_total - en0, k);
  endtask

  task automatic do_reset_cmd();
    int r0 = rst_pulses;
    send_byte(C_RST);
    repeat (3) tick();
    wb_halt = 1'b0;
    check("rst_pulse_count", rst_pulses - r0, 1);
    check("rst_halted_clear", halted, 0);
  endtask

  initial begin
    int base, en0, k;
    logic [7:0] junk;

    randomize_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pipe_en", pipe_en, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_pipe_reset", pipe_reset, 0);
    check("reset_halted", halted, 0);
    check("reset_reg_addr", dbg_reg_addr, 0);
    check("reset_mem_addr", dbg_mem_addr, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Single step with fixed PC and marker register/memory values.
    pc_base = 32'h0000_0008;
    regs[5] = 32'hDEAD_BEEF;
    mem_model[2] = 32'h1234_5678;
    base = cap.size();
    en0 = en_total;
    k = addr8_hits;
    send_byte(C_STEP);
    check_dump("step", base);
    check("step_en_cycles", en_total - en0, 1);
    check("step_b0", cap[base + 0], 8'h08);
    check("step_b3", cap[base + 3], 8'h00);
    check("r5_b24", cap[base + 24], 8'hEF);
    check("r5_b27", cap[base + 27], 8'hDE);
    check("mem2_b140", cap[base + 140], 8'h78);
    check("mem2_b143", cap[base + 143], 8'h12);
    check("mem_addr8_seen", (addr8_hits - k) > 0, 1);
    check("step_not_halted", halted, 0);

    // Unknown command bytes are ignored.
    base = cap.size();
    en0 = en_total;
    for (int i = 0; i < 6; i++) begin
      junk = 8'($urandom);
      if (junk == C_RUN || junk == C_STEP || junk == C_RST) junk = 8'h00;
      send_byte(junk);
      tick();
    end
    repeat (20) tick();
    check("junk_no_en", en_total - en0, 0);
    check("junk_no_tx", cap.size() - base, 0);

    // Run for 10 cycles, then halt.
    do_reset_cmd();
    randomize_model();
    base = cap.size();
    do_run(10);
    check_dump("run10", base);

    // Commands while halted are ignored; 'R' clears the halt.
    base = cap.size();
    en0 = en_total;
    send_byte(C_RUN);
    repeat (5) tick();
    send_byte(C_STEP);
    repeat (30) tick();
    check("halted_no_en", en_total - en0, 0);
    check("halted_no_tx", cap.size() - base, 0);
    check("halted_still", halted, 1);
    do_reset_cmd();

    // Slow transmitter; a step command mid-dump is dropped.
    busy_fixed = 50;
    randomize_model();
    base = cap.size();
    en0 = en_total;
    send_byte(C_STEP);
    k = 0;
    while (cap.size() < base + 10 && k < 2000) begin
      tick();
      k++;
    end
    send_byte(C_STEP);
    check_dump("slow", base);
    repeat (300) tick();
    check("slow_no_extra_tx", cap.size() - base, DUMP_BYTES);
    check("slow_en_cycles", en_total - en0, 1);
    busy_fixed = 0;

    // Randomised runs, the first one 100 cycles long.
    for (int it = 0; it < 3; it++) begin
      do_reset_cmd();
      randomize_model();
      base = cap.size();
      do_run((it == 0) ? 100 : int'($urandom_range(40, 1)));
      check_dump($sformatf("rand%0d", it), base);
    end

    // Step that coincides with a halt, then async reset mid-dump.
    do_reset_cmd();
    randomize_model();
    wb_halt = 1'b1;
    base = cap.size();
    send_byte(C_STEP);
    repeat (2) tick();
    check("step_halt_flag", halted, 1);
    k = 0;
    while (cap.size() < base + 20 && k < 2000) begin
      tick();
      k++;
    end
    check("pre_reset_progress", cap.size() >= base + 20, 1);
    reset = 1'b0;
    #1;
    check("areset_tx_start", tx_start, 0);
    check("areset_halted", halted, 0);
    check("areset_pipe_en", pipe_en, 0);
    repeat (3) tick();
    reset = 1'b1;
    wb_halt = 1'b0;
    base = cap.size();
    repeat (200) tick();
    check("areset_no_tx", cap.size() - base, 0);
    check("tx_while_busy", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
